// File: rtl/ir_frame_ctrl.sv
// IR frame controller: collects decoded IR bits MSB-first into a frame,
// hands the frame to a consumer with valid/ready, and aborts on front-end
// error or inter-bit timeout.
module ir_frame_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TMO_W  = 16,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bit_valid,
  input  logic              bit_val,
  input  logic              err_in,
  input  logic [TMO_W-1:0]  tmo_cycles,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_valid,
  output logic              finish,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              overrun,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] HOLD = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [1:0] EC_NONE = 2'b00;
  localparam logic [1:0] EC_FE   = 2'b01;
  localparam logic [1:0] EC_TMO  = 2'b10;

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [TMO_W-1:0]  r_timer;
  logic [DATA_W-1:0] r_frame_data;
  logic              r_frame_valid;
  logic              r_finish;
  logic              r_error;
  logic [1:0]        r_err_code;
  logic              r_overrun;
  logic              r_busy;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic [2:0]        w_state_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic [TMO_W-1:0]  w_timer_nxt;
  logic [DATA_W-1:0] w_frame_data_nxt;
  logic [1:0]        w_err_code_nxt;
  logic              w_overrun_nxt;
  logic [FCNT_W-1:0] w_frame_cnt_nxt;
  logic [DATA_W-1:0] w_shift_in;
  logic              w_tmo_hit;

  assign w_shift_in = {r_shift[DATA_W-2:0], bit_val};
  assign w_tmo_hit  = (tmo_cycles != '0) && (r_timer == tmo_cycles - TMO_W'(1));

  // Next-state and next-value logic for state and datapath registers
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_timer_nxt      = r_timer;
    w_frame_data_nxt = r_frame_data;
    w_err_code_nxt   = r_err_code;
    w_overrun_nxt    = r_overrun;
    w_frame_cnt_nxt  = r_frame_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt    = READ;
          w_shift_nxt    = '0;
          w_bit_cnt_nxt  = '0;
          w_timer_nxt    = '0;
          w_err_code_nxt = EC_NONE;
          w_overrun_nxt  = 1'b0;
        end
      end
      READ: begin
        if (err_in) begin
          w_state_nxt    = ERR;
          w_err_code_nxt = EC_FE;
        end else if (bit_valid) begin
          w_shift_nxt   = w_shift_in;
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          w_timer_nxt   = '0;
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_state_nxt      = HOLD;
            w_frame_data_nxt = w_shift_in;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt    = ERR;
          w_err_code_nxt = EC_TMO;
        end else if (tmo_cycles != '0) begin
          w_timer_nxt = r_timer + TMO_W'(1);
        end
      end
      HOLD: begin
        if (bit_valid) begin
          w_overrun_nxt = 1'b1;
        end
        if (frame_ready) begin
          w_state_nxt     = DONE;
          w_frame_cnt_nxt = r_frame_cnt + FCNT_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; pulses/flags follow the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_timer       <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_finish      <= 1'b0;
      r_error       <= 1'b0;
      r_err_code    <= EC_NONE;
      r_overrun     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_timer       <= w_timer_nxt;
      r_frame_data  <= w_frame_data_nxt;
      r_frame_valid <= (w_state_nxt == HOLD);
      r_finish      <= (w_state_nxt == DONE);
      r_error       <= (w_state_nxt == ERR);
      r_err_code    <= w_err_code_nxt;
      r_overrun     <= w_overrun_nxt;
      r_busy        <= (w_state_nxt != IDLE);
      r_frame_cnt   <= w_frame_cnt_nxt;
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_valid = r_frame_valid;
  assign finish      = r_finish;
  assign error       = r_error;
  assign err_code    = r_err_code;
  assign overrun     = r_overrun;
  assign busy        = r_busy;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: doc/ir_frame_ctrl.md
IR_FRAME_CTRL -- requirements
Module: ir_frame_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the frame payload width in bits (legal 2..64).
REQ-002 Parameter TMO_W, default 16, SHALL set the width of the inter-bit timeout counter and of tmo_cycles.
REQ-003 Parameter FCNT_W, default 16, SHALL set the width of the completed-frame counter.
REQ-004 Ports SHALL be, clock and reset first:
 clk  in  1  rising-edge clock
 reset  in  1  asynchronous, active-low reset
 start  in  1  request to begin capturing a frame
 bit_valid  in  1  one-cycle strobe: a decoded IR bit is present
 bit_val  in  1  value of the decoded bit, qualified by bit_valid
 err_in  in  1  front-end protocol error strobe
 tmo_cycles  in  TMO_W  inter-bit timeout in clk cycles; 0 disables timeout
 frame_ready  in  1  consumer accepts frame_data
 frame_data  out  DATA_W  captured payload, first-received bit in MSB
 frame_valid  out  1  frame_data valid, held until accepted
 finish  out  1  one-cycle pulse after frame accepted
 error  out  1  one-cycle pulse on frame abort
 err_code  out  2  00 none, 01 front-end error, 10 timeout
 overrun  out  1  sticky: bit_valid arrived while frame held
 busy  out  1  high in any state other than IDLE
 frame_cnt  out  FCNT_W  count of accepted frames, wraps to 0

Function
REQ-005 The block SHALL implement states IDLE, READ, HOLD, DONE, ERR.
REQ-006 IDLE: start=1 SHALL move to READ next cycle, clearing shift register, bit counter, timer, err_code and overrun.
REQ-007 IDLE: bit_valid and err_in SHALL be ignored.
REQ-008 READ: bit_valid=1 SHALL shift bit_val into the LSB of the shift register (older bits move toward MSB), increment the bit counter and clear the timer.
REQ-009 READ: the bit_valid that brings the bit count to DATA_W SHALL move to HOLD with frame_valid=1 and frame_data equal to the full shift register in the next cycle.
REQ-010 READ: err_in=1 SHALL move to ERR with err_code=01, taking priority over bit_valid and timeout in the same cycle.
REQ-011 READ: with tmo_cycles!=0, timer SHALL increment each cycle without bit_valid; when it reaches tmo_cycles-1 with no bit_valid that cycle, state SHALL move to ERR with err_code=10.
REQ-012 READ: bit_valid in the same cycle as timer expiry SHALL win; no timeout.
REQ-013 READ: start SHALL be ignored (no restart mid-frame).
REQ-014 HOLD: frame_valid and frame_data SHALL stay stable until frame_ready=1; that cycle SHALL move to DONE and increment frame_cnt modulo 2^FCNT_W.
REQ-015 HOLD: bit_valid=1 SHALL set overrun and be discarded; err_in SHALL be ignored; no timeout.
REQ-016 DONE: finish=1 for exactly one cycle, then IDLE; frame_valid=0 in DONE.
REQ-017 ERR: error=1 for exactly one cycle, then IDLE; err_code SHALL hold until the next accepted start.
REQ-018 frame_data SHALL retain its last value after HOLD until the next frame completes.
REQ-019 Unreachable state encodings SHALL return to IDLE next cycle with all pulse outputs low.
REQ-020 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-021 reset=0 SHALL immediately force IDLE, frame_data=0, frame_valid=0, finish=0, error=0, err_code=00, overrun=0, busy=0, frame_cnt=0, timer and bit counter 0.
REQ-022 Reset asserted mid-frame (READ or HOLD) SHALL discard the partial/held frame with no finish or error pulse.
REQ-023 After reset release, the first rising edge SHALL evaluate IDLE transitions normally.

Verification (DATA_W=8, tmo_cycles=5)
REQ-024 start, then bits 1,0,1,1,0,0,1,0 at arbitrary spacing <5 cycles, frame_ready tied 1 -> frame_data=0xB2, frame_valid one cycle, finish next cycle, frame_cnt=1.
REQ-025 start, 3 bits, then 5 idle cycles -> error pulse, err_code=10, frame_valid never asserted, busy low after ERR.
REQ-026 start, 4 bits, err_in and bit_valid same cycle -> ERR, err_code=01; next start clears err_code to 00.
REQ-027 full frame with frame_ready=0 for 10 cycles and a bit_valid during wait -> frame_data stable, overrun=1, finish only after frame_ready=1.
REQ-028 FCNT_W=2, four accepted frames -> frame_cnt sequence 1,2,3,0.
REQ-029 reset pulsed while in READ after 5 bits -> all outputs at reset values, no finish/error pulse, next frame captures correctly.
